cgra_dma_arbiter: RTL and testbench

Shares the single CGRA DMA engine between up to NUM_REQ requesters: control unit, configuration loader, host CSR path and spike write-back. It accepts one descriptor at a time, with an urgent class, round-robin fairness, per-transfer completion and error responses, and a completion watchdog. It sits between the requesters and the DMA engine's trigger/busy/done/error interface and replaces direct `dma_trigger` drive by any single master.

---
 rtl/cgra_dma_arbiter_if.sv | 44 ++++
 rtl/cgra_dma_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cgra_dma_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_dma_arbiter_if.sv
// Requester and DMA-engine signal bundle for the CGRA DMA arbiter.
// The master modport is the arbiter's view; slave is the requester/engine side.
interface cgra_dma_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_urgent;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_done;
    logic [NUM_REQ-1:0]        resp_error;
    logic                      dma_trigger;
    logic                      dma_abort;
    logic [ADDR_W-1:0]         dma_addr;
    logic [LEN_W-1:0]          dma_len;
    logic                      dma_busy;
    logic                      dma_done;
    logic                      dma_error;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;
    logic [31:0]               perf_grants;
    logic [31:0]               perf_timeouts;

    modport master (
        input  req_valid, req_urgent, req_addr, req_len,
        input  dma_busy, dma_done, dma_error,
        output req_ready, resp_done, resp_error,
        output dma_trigger, dma_abort, dma_addr, dma_len,
        output grant_valid, grant_id, perf_grants, perf_timeouts
    );

    modport slave (
        output req_valid, req_urgent, req_addr, req_len,
        output dma_busy, dma_done, dma_error,
        input  req_ready, resp_done, resp_error,
        input  dma_trigger, dma_abort, dma_addr, dma_len,
        input  grant_valid, grant_id, perf_grants, perf_timeouts
    );
endinterface

// File: rtl/cgra_dma_arbiter.sv
// Arbiter sharing one CGRA DMA engine among NUM_REQ requesters with an urgent
// class, shared round-robin pointer, per-transfer responses and a watchdog.
module cgra_dma_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    cgra_dma_arbiter_if.master  bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [WD_W-1:0]     wd_r;
    logic                pend_r;
    logic                pend_err_r;
    logic [NUM_REQ-1:0]  req_ready_r;
    logic [NUM_REQ-1:0]  resp_done_r;
    logic [NUM_REQ-1:0]  resp_error_r;
    logic                dma_trigger_r;
    logic                dma_abort_r;
    logic [ADDR_W-1:0]   dma_addr_r;
    logic [LEN_W-1:0]    dma_len_r;
    logic                grant_valid_r;
    logic [ID_W-1:0]     grant_id_r;
    logic [31:0]         perf_grants_r;
    logic [31:0]         perf_timeouts_r;

    logic [NUM_REQ-1:0]  urgent_s;
    logic [NUM_REQ-1:0]  cand_s;
    logic [ID_W:0]       idx_s;
    logic                win_found_s;
    logic [ID_W-1:0]     win_id_s;
    logic [ID_W-1:0]     rr_next_s;

    // Winner selection: urgent requesters mask out normal ones, then round-robin from rr_ptr.
    always_comb begin
        urgent_s    = bus.req_valid & bus.req_urgent;
        win_found_s = 1'b0;
        win_id_s    = '0;
        idx_s       = '0;
        if (|urgent_s) begin
            cand_s = urgent_s;
        end else begin
            cand_s = bus.req_valid;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
            if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
                idx_s = idx_s - (ID_W+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (cand_s[idx_s[ID_W-1:0]] && !win_found_s) begin
                win_found_s = 1'b1;
                win_id_s    = idx_s[ID_W-1:0];
            end else begin
                win_id_s    = win_id_s;
            end
        end
        if (win_id_s == ID_W'(NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = win_id_s + ID_W'(1);
        end
    end

    // Transfer FSM; every output is a register, pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            rr_ptr_r        <= '0;
            wd_r            <= '0;
            pend_r          <= 1'b0;
            pend_err_r      <= 1'b0;
            req_ready_r     <= '0;
            resp_done_r     <= '0;
            resp_error_r    <= '0;
            dma_trigger_r   <= 1'b0;
            dma_abort_r     <= 1'b0;
            dma_addr_r      <= '0;
            dma_len_r       <= '0;
            grant_valid_r   <= 1'b0;
            grant_id_r      <= '0;
            perf_grants_r   <= 32'd0;
            perf_timeouts_r <= 32'd0;
        end else begin
            req_ready_r   <= '0;
            resp_done_r   <= '0;
            resp_error_r  <= '0;
            dma_trigger_r <= 1'b0;
            dma_abort_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        dma_addr_r            <= bus.req_addr[win_id_s*ADDR_W +: ADDR_W];
                        dma_len_r             <= bus.req_len[win_id_s*LEN_W +: LEN_W];
                        grant_id_r            <= win_id_s;
                        grant_valid_r         <= 1'b1;
                        req_ready_r[win_id_s] <= 1'b1;
                        perf_grants_r         <= perf_grants_r + 32'd1;
                        rr_ptr_r              <= rr_next_s;
                        state_r               <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Zero-length and timeout outcomes are reported one cycle into RELEASE.
                    if (dma_len_r == '0) begin
                        pend_r     <= 1'b1;
                        pend_err_r <= 1'b0;
                        state_r    <= RELEASE;
                    end else if (!bus.dma_busy) begin
                        dma_trigger_r <= 1'b1;
                        wd_r          <= '0;
                        state_r       <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.dma_error) begin
                        resp_error_r[grant_id_r] <= 1'b1;
                        state_r                  <= RELEASE;
                    end else if (bus.dma_done) begin
                        resp_done_r[grant_id_r]  <= 1'b1;
                        state_r                  <= RELEASE;
                    end else if (wd_r == WD_W'(TIMEOUT)) begin
                        dma_abort_r     <= 1'b1;
                        pend_r          <= 1'b1;
                        pend_err_r      <= 1'b1;
                        perf_timeouts_r <= perf_timeouts_r + 32'd1;
                        state_r         <= RELEASE;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                RELEASE: begin
                    if (pend_r) begin
                        pend_r <= 1'b0;
                        if (pend_err_r) begin
                            resp_error_r[grant_id_r] <= 1'b1;
                        end else begin
                            resp_done_r[grant_id_r]  <= 1'b1;
                        end
                    end else begin
                        grant_valid_r <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_r;
    assign bus.resp_done     = resp_done_r;
    assign bus.resp_error    = resp_error_r;
    assign bus.dma_trigger   = dma_trigger_r;
    assign bus.dma_abort     = dma_abort_r;
    assign bus.dma_addr      = dma_addr_r;
    assign bus.dma_len       = dma_len_r;
    assign bus.grant_valid   = grant_valid_r;
    assign bus.grant_id      = grant_id_r;
    assign bus.perf_grants   = perf_grants_r;
    assign bus.perf_timeouts = perf_timeouts_r;
endmodule

// File: tb/tb_cgra_dma_arbiter.sv
// Directed self-checking bench for cgra_dma_arbiter (TIMEOUT reduced to 15).
module tb_cgra_dma_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   grant_log [8];
    int   grant_cnt;
    int   trig_cnt;
    int   cyc;
    int   abort_cyc;

    cgra_dma_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    cgra_dma_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_urgent = '0;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        bus.dma_busy   = 1'b0;
        bus.dma_done   = 1'b0;
        bus.dma_error  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        bus.req_addr[id*ADDR_W +: ADDR_W] = addr;
        bus.req_len[id*LEN_W +: LEN_W]    = len;
        bus.req_valid[id]                 = 1'b1;
    endtask

    // Engine answers each trigger with done in the same cycle; oneshot requesters drop after grant.
    task automatic collect(input int n, input logic oneshot);
        grant_cnt = 0;
        cyc       = 0;
        while (grant_cnt < n && cyc < 300) begin
            tick();
            cyc++;
            bus.dma_done = bus.dma_trigger;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i] && grant_cnt < 8) begin
                    grant_log[grant_cnt] = i;
                    grant_cnt++;
                    if (oneshot) bus.req_valid[i] = 1'b0;
                end
            end
        end
        bus.dma_done = 1'b0;
        chk("grant_count", 64'(grant_cnt), 64'(n));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset values
        do_reset();
        chk("rst_req_ready",   64'(bus.req_ready),   64'h0);
        chk("rst_grant_valid", 64'(bus.grant_valid), 64'h0);
        chk("rst_perf_grants", 64'(bus.perf_grants), 64'h0);
        chk("rst_dma_addr",    64'(bus.dma_addr),    64'h0);
        chk("rst_trigger",     64'(bus.dma_trigger), 64'h0);

        // Single request, requester 2
        set_req(2, 32'h0000_1000, 16'd64);
        tick();
        chk("single_ready",    64'(bus.req_ready),   64'h4);
        chk("single_gvalid",   64'(bus.grant_valid), 64'h1);
        chk("single_gid",      64'(bus.grant_id),    64'h2);
        bus.req_valid = '0;
        tick();
        chk("single_trigger",  64'(bus.dma_trigger), 64'h1);
        chk("single_addr",     64'(bus.dma_addr),    64'h1000);
        chk("single_len",      64'(bus.dma_len),     64'd64);
        for (int i = 0; i < 10; i++) tick();
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        chk("single_resp_done", 64'(bus.resp_done),  64'h4);
        chk("single_resp_err",  64'(bus.resp_error), 64'h0);
        tick();
        chk("single_resp_pulse", 64'(bus.resp_done),  64'h0);
        chk("single_release",    64'(bus.grant_valid), 64'h0);
        chk("single_perf",       64'(bus.perf_grants), 64'h1);

        // Round-robin with all four continuously valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h2000 + 32'(i), 16'd8);
        collect(6, 1'b0);
        chk("rr_0", 64'(grant_log[0]), 64'd0);
        chk("rr_1", 64'(grant_log[1]), 64'd1);
        chk("rr_2", 64'(grant_log[2]), 64'd2);
        chk("rr_3", 64'(grant_log[3]), 64'd3);
        chk("rr_4", 64'(grant_log[4]), 64'd0);
        chk("rr_5", 64'(grant_log[5]), 64'd1);

        // Urgent override
        do_reset();
        set_req(0, 32'h3000, 16'd4);
        set_req(1, 32'h3100, 16'd4);
        set_req(3, 32'h3300, 16'd4);
        bus.req_urgent[3] = 1'b1;
        collect(3, 1'b1);
        chk("urg_first",  64'(grant_log[0]), 64'd3);
        chk("urg_second", 64'(grant_log[1]), 64'd0);
        chk("urg_third",  64'(grant_log[2]), 64'd1);

        // Busy hold: engine busy for cycles 1..21, free from cycle 22
        do_reset();
        bus.dma_busy = 1'b1;
        set_req(1, 32'h4000, 16'd4);
        trig_cnt = 0;
        tick();
        chk("busy_ready", 64'(bus.req_ready), 64'h2);
        bus.req_valid = '0;
        for (int i = 0; i < 20; i++) begin
            trig_cnt += int'(bus.dma_trigger);
            tick();
        end
        trig_cnt += int'(bus.dma_trigger);
        bus.dma_busy = 1'b0;
        chk("busy_no_trigger", 64'(trig_cnt), 64'd0);
        tick();
        chk("busy_trigger", 64'(bus.dma_trigger), 64'h1);
        tick();
        chk("busy_trigger_once", 64'(bus.dma_trigger), 64'h0);

        // done and error together: error wins
        do_reset();
        set_req(0, 32'h5000, 16'd4);
        tick();
        bus.req_valid = '0;
        tick();
        chk("err_trigger", 64'(bus.dma_trigger), 64'h1);
        bus.dma_done  = 1'b1;
        bus.dma_error = 1'b1;
        tick();
        bus.dma_done  = 1'b0;
        bus.dma_error = 1'b0;
        chk("err_resp_error", 64'(bus.resp_error), 64'h1);
        chk("err_resp_done",  64'(bus.resp_done),  64'h0);

        // Watchdog: trigger at cycle 2, abort at 18, resp_error at 19
        do_reset();
        set_req(2, 32'h6000, 16'd5);
        tick();
        bus.req_valid = '0;
        tick();
        chk("wd_trigger", 64'(bus.dma_trigger), 64'h1);
        cyc       = 2;
        abort_cyc = -1;
        while (abort_cyc < 0 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.dma_abort) abort_cyc = cyc;
        end
        chk("wd_abort_cycle",  64'(abort_cyc),          64'd18);
        chk("wd_no_early_err", 64'(bus.resp_error),     64'h0);
        tick();
        chk("wd_resp_error",   64'(bus.resp_error),     64'h4);
        chk("wd_abort_pulse",  64'(bus.dma_abort),      64'h0);
        chk("wd_perf",         64'(bus.perf_timeouts),  64'h1);
        tick();
        chk("wd_released",     64'(bus.grant_valid),    64'h0);
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        tick();
        chk("stray_done_ignored", 64'(bus.resp_done), 64'h0);

        // Zero length: ready at 1, resp_done at 3, never a trigger
        do_reset();
        set_req(3, 32'h7000, 16'd0);
        trig_cnt = 0;
        tick();
        chk("zl_ready", 64'(bus.req_ready), 64'h8);
        bus.req_valid = '0;
        tick();
        trig_cnt += int'(bus.dma_trigger);
        chk("zl_no_early_done", 64'(bus.resp_done), 64'h0);
        tick();
        trig_cnt += int'(bus.dma_trigger);
        chk("zl_resp_done", 64'(bus.resp_done), 64'h8);
        tick();
        trig_cnt += int'(bus.dma_trigger);
        chk("zl_no_trigger", 64'(trig_cnt), 64'd0);

        // Reset while in WAIT_DONE
        do_reset();
        set_req(1, 32'h8000, 16'd4);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_gvalid", 64'(bus.grant_valid), 64'h0);
        chk("mrst_addr",   64'(bus.dma_addr),    64'h0);
        chk("mrst_perf",   64'(bus.perf_grants), 64'h0);
        chk("mrst_resp",   64'({bus.resp_done, bus.resp_error, bus.dma_abort}), 64'h0);
        tick();
        chk("mrst_no_resp", 64'({bus.resp_done, bus.resp_error, bus.dma_abort}), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
